// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the sync_ram_be memory block and its read pipeline.
package sync_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } clr_state_t;

    localparam int MAX_READ_LATENCY = 4;
    localparam int BYTE_W           = 8;

endpackage

// File: rtl/sync_ram_rd_pipe.sv
// READ_LATENCY-deep delay line carrying read valid, range error and data.
// A synchronous flush on rst_n drops every in-flight read.
module sync_ram_rd_pipe
    import sync_ram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_in,
    input  logic              err_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              rvalid,
    output logic              rerr,
    output logic [DATA_W-1:0] rdata
);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("sync_ram_rd_pipe: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
    end

    logic [READ_LATENCY-1:0] vld_p;
    logic [READ_LATENCY-1:0] err_p;
    logic [DATA_W-1:0]       data_p [READ_LATENCY];

    // Data only advances behind a valid, so the last stage holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
            err_p <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= vld_in;
            err_p[0] <= vld_in & err_in;
            if (vld_in) begin
                data_p[0] <= data_in;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                err_p[i] <= err_p[i-1];
                if (vld_p[i-1]) begin
                    data_p[i] <= data_p[i-1];
                end
            end
        end
    end

    assign rvalid = vld_p[READ_LATENCY-1];
    assign rerr   = err_p[READ_LATENCY-1];
    assign rdata  = data_p[READ_LATENCY-1];

endmodule

// File: rtl/sync_ram_be.sv
// Single-port synchronous RAM with byte-enable writes, req/ready handshake and pipelined reads.
// Define RAM_CLEAR_EN to zero the whole array after every reset before accepting accesses.
module sync_ram_be
    import sync_ram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 9,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W/BYTE_W-1:0] be,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     ready,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic                     rerr
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    if (DATA_W % BYTE_W != 0) begin : g_bad_width
        $error("sync_ram_be: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("sync_ram_be: DEPTH must be 1..2**ADDR_W");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_data;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_idx;

    // Range check uses the full address, so out-of-range accesses never alias.
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign acc      = req & ready & rst_n;
    assign wr_acc   = acc & we & in_range;
    assign rd_acc   = acc & ~we;
    assign idx      = addr[IDX_W-1:0];
    assign rd_data  = in_range ? mem[idx] : '0;

`ifdef RAM_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        clr_we  = 1'b0;
        ready   = 1'b0;
        case (state_q)
            IDLE:  state_d = CLEAR;
            CLEAR: begin
                clr_we = rst_n;
                if (cnt_q == LAST) begin
                    state_d = READY;
                end
            end
            READY: ready = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign clr_idx = cnt_q[IDX_W-1:0];
`else
    logic ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
        end
    end

    assign ready   = ready_q;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    // Storage is never reset; only the clear sequencer or a write touches it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    sync_ram_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (rd_acc),
        .err_in  (~in_range),
        .data_in (rd_data),
        .rvalid  (rvalid),
        .rerr    (rerr),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_sync_ram_be.sv
// Directed, table-driven bench for sync_ram_be (DEPTH=300, READ_LATENCY=3).
module tb_sync_ram_be;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 300;
    localparam int RL     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [3:0]        be = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rerr;

    int n_checks = 0;
    int n_fail   = 0;

    sync_ram_be #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .be     (be),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rerr   (rerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [8:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp;
        bit          err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (ready !== 1'b1 && n < DEPTH + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_write(input logic [8:0] a, input logic [3:0] b, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
    endtask

    // rvalid must be low for RL-1 cycles after the accept, then high with the data.
    task automatic do_read(input logic [8:0] a, input logic [31:0] exp, input bit err, input string name);
        req = 1'b1; we = 1'b0; addr = a; be = 4'h0;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int k = 1; k <= RL; k++) begin
            check($sformatf("%s_rvalid_c%0d", name, k), 32'(rvalid), 32'(k == RL));
            if (k == RL) begin
                check($sformatf("%s_rdata", name), rdata, exp);
                check($sformatf("%s_rerr", name), 32'(rerr), 32'(err));
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] sexp [3];

        // Reset state
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rerr", 32'(rerr), 32'd0);
        check("reset_rdata", rdata, 32'd0);
`ifdef RAM_CLEAR_EN
        check("reset_ready", 32'(ready), 32'd0);
        wait_clear(n);
        check("clear_cycles", 32'(n), 32'(DEPTH));
        do_read(9'd5, 32'd0, 1'b0, "clr_rd5");
        do_read(9'd299, 32'd0, 1'b0, "clr_rd299");
        // Reset at clear cycle 100 restarts the full sweep
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        check("clear_mid_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear(n);
        check("clear_restart_cycles", 32'(n), 32'(DEPTH));
`else
        check("reset_ready", 32'(ready), 32'd1);
`endif

        vecs.push_back(vec_t'{1'b1, 9'd0,   4'hF, 32'h0000_0001, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd1,   4'hF, 32'h0000_0002, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd2,   4'hF, 32'h0000_0004, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd0,   4'h0, 32'h0, 32'h0000_0001, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd1,   4'h0, 32'h0, 32'h0000_0002, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd2,   4'h0, 32'h0, 32'h0000_0004, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd5,   4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd5,   4'h5, 32'h0000_0000, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd5,   4'h0, 32'h0, 32'hFF00_FF00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd7,   4'hF, 32'h0000_00A5, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd7,   4'h0, 32'h0, 32'h0000_00A5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd144, 4'hF, 32'h1234_5678, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd400, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd400, 4'h0, 32'h0, 32'h0000_0000, 1'b1});
        vecs.push_back(vec_t'{1'b0, 9'd144, 4'h0, 32'h0, 32'h1234_5678, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd3,   4'hF, 32'h1122_3344, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd3,   4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd3,   4'h0, 32'h0, 32'h1122_3344, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd299, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd299, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd300, 4'h0, 32'h0, 32'h0000_0000, 1'b1});
        vecs.push_back(vec_t'{1'b1, 9'd6,   4'h6, 32'hAABB_CCDD, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 9'd6,   4'h9, 32'h1100_0022, 32'h0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 9'd6,   4'h0, 32'h0, 32'h11BB_CC22, 1'b0});

        foreach (vecs[i]) begin
            if (vecs[i].w) begin
                do_write(vecs[i].a, vecs[i].be, vecs[i].d);
            end else begin
                do_read(vecs[i].a, vecs[i].exp, vecs[i].err, $sformatf("v%0d", i));
            end
        end

        // Back-to-back reads stream one result per cycle, then rdata holds
        sexp[0] = 32'h1; sexp[1] = 32'h2; sexp[2] = 32'h4;
        for (int c = 0; c < 3 + RL + 1; c++) begin
            int j;
            if (c < 3) begin
                req = 1'b1; we = 1'b0; addr = 9'(c);
            end else begin
                req = 1'b0;
            end
            @(posedge clk);
            #1;
            j = c - (RL - 1);
            if (j >= 0 && j < 3) begin
                check($sformatf("stream_rvalid_c%0d", c), 32'(rvalid), 32'd1);
                check($sformatf("stream_rdata_c%0d", c), rdata, sexp[j]);
            end else begin
                check($sformatf("stream_rvalid_c%0d", c), 32'(rvalid), 32'd0);
            end
        end
        check("stream_rdata_hold", rdata, 32'h4);

        // Reset on the cycle after the 2nd accept discards all three reads
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                req = 1'b1; we = 1'b0; addr = 9'(c);
            end else begin
                req = 1'b0;
            end
            rst_n = (c == 2) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("flush_rvalid_c%0d", c), 32'(rvalid), 32'd0);
            if (c == 2) begin
                check("flush_rdata_zero", rdata, 32'd0);
                check("flush_rerr_zero", 32'(rerr), 32'd0);
            end
        end
        rst_n = 1'b1;
`ifdef RAM_CLEAR_EN
        wait_clear(n);
        check("flush_clear_cycles", 32'(n), 32'(DEPTH - 5));
`else
        check("flush_ready", 32'(ready), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
